// File: rtl/avalon_reader_pkg.sv
// Shared types and constants for the Avalon-MM block reader.
package avalon_reader_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    FIN
  } state_t;

  localparam int         BYTES_PER_WORD = 4;
  localparam logic [3:0] BYTEENABLE_ALL = 4'hF;

endpackage

// File: rtl/stream_fifo.sv
// Synchronous show-ahead FIFO: pop_data always presents the oldest entry.
module stream_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [DATA_W-1:0]        push_data,
  input  logic                     pop,
  output logic [DATA_W-1:0]        pop_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign empty    = (count == '0);
  assign full     = (count == CNT_W'(DEPTH));
  assign pop_data = mem[rd_ptr];

  // NOTE: the storage array has no reset; only pointers and count decide what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/avalon_mm_block_reader.sv
// Avalon-MM pipelined read master: fetches a block of words and streams them out in order.
module avalon_mm_block_reader
  import avalon_reader_pkg::*;
#(
  parameter int ADDR_W     = 12,
  parameter int DATA_W     = 32,
  parameter int LEN_W      = 11,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [LEN_W-1:0]  length,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  output logic [3:0]        avm_byteenable,
  input  logic              avm_waitrequest,
  input  logic [DATA_W-1:0] avm_readdata,
  input  logic              avm_readdatavalid,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int SUM_W = CNT_W + 1;
  localparam logic [SUM_W-1:0]  CREDIT_LIMIT = SUM_W'(FIFO_DEPTH);
  localparam logic [ADDR_W-1:0] WORD_MASK    = ~ADDR_W'(BYTES_PER_WORD - 1);

  state_t             state;
  logic [ADDR_W-1:0]  addr;
  logic [LEN_W-1:0]   rem_issue;
  logic [LEN_W-1:0]   rem_recv;
  logic [CNT_W-1:0]   outstanding;
  logic [CNT_W-1:0]   fifo_count;
  logic               fifo_empty;
  logic               fifo_full;
  logic [SUM_W-1:0]   in_use;
  logic               active;
  logic               accept;
  logic               push;
  logic               pop;

  assign avm_address    = addr;
  assign avm_byteenable = BYTEENABLE_ALL;
  assign out_valid      = !fifo_empty;

  // NOTE: every signal here is assigned on every pass, so no latch can be inferred.
  always_comb begin
    active   = (state == ISSUE) || (state == DRAIN);
    in_use   = SUM_W'(outstanding) + SUM_W'(fifo_count);
    // Credit check: a request is only issued when a FIFO slot is guaranteed for its data.
    avm_read = (state == ISSUE) && (rem_issue != '0) && (in_use < CREDIT_LIMIT);
    accept   = avm_read && !avm_waitrequest;
    push     = avm_readdatavalid && active && !fifo_full;
    pop      = out_valid && out_ready;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      addr      <= '0;
      rem_issue <= '0;
      rem_recv  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (pop && rem_recv != '0) rem_recv <= rem_recv - LEN_W'(1);
      case (state)
        IDLE: begin
          if (start) begin
            busy <= 1'b1;
            if (length != '0) begin
              addr      <= start_addr & WORD_MASK;
              rem_issue <= length;
              rem_recv  <= length;
              state     <= ISSUE;
            end else begin
              state <= FIN;
            end
          end
        end
        ISSUE: begin
          if (accept) begin
            addr      <= addr + ADDR_W'(BYTES_PER_WORD);
            rem_issue <= rem_issue - LEN_W'(1);
            if (rem_issue == LEN_W'(1)) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (rem_recv == '0) state <= FIN;
        end
        FIN: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      outstanding <= '0;
    end else begin
      case ({accept, push})
        2'b10:   outstanding <= outstanding + CNT_W'(1);
        2'b01:   outstanding <= outstanding - CNT_W'(1);
        default: outstanding <= outstanding;
      endcase
    end
  end

  stream_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (avm_readdata),
    .pop       (pop),
    .pop_data  (out_data),
    .count     (fifo_count),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

endmodule
